// File: rtl/jtvigil_pkg.sv
// Shared types for the jtvigil ROM responder: fetch FSM states and default widths.
package jtvigil_pkg;
    localparam int ROM_AW   = 18;
    localparam int SDRAM_AW = 17;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        LO,
        REQ2,
        HI
    } fetch_state_t;
endpackage

// File: rtl/jtvigil_romrsp_line.sv
// One cache line (tag, valid, 32-bit word); write lands on the next clk edge.
// No backpressure: a write strobe always wins over a concurrent invalidate.
module jtvigil_romrsp_line #(
    parameter int TW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic          wvld,
    input  logic          clr,
    input  logic [TW-1:0] wtag,
    input  logic [31:0]   wdat,
    output logic          valid,
    output logic [TW-1:0] tag,
    output logic [31:0]   data
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            tag   <= '0;
            data  <= '0;
        end else if (we) begin
            valid <= wvld;
            tag   <= wtag;
            data  <= wdat;
        end else if (clr) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/jtvigil_romrsp.sv
// 2-entry LRU word cache in front of a 16-bit SDRAM port; hit latency 1 clk, miss = 2 SDRAM round trips + 2 clk.
// sdram_req is held until sdram_ack; an accepted fetch always runs to completion, flush only discards its result.
module jtvigil_romrsp
    import jtvigil_pkg::*;
#(
    parameter int AW = ROM_AW,
    parameter int SW = SDRAM_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rom_cs,
    input  logic [AW-1:0] rom_addr,
    output logic [31:0]   rom_data,
    output logic          rom_ok,
    input  logic          flush,
    output logic          sdram_req,
    output logic [SW-1:0] sdram_addr,
    input  logic          sdram_ack,
    input  logic          sdram_dok,
    input  logic [15:0]   sdram_data
);
    localparam int TW = AW - 2;

    fetch_state_t  state, nxt_state;
    logic [TW-1:0] cur_tag;
    logic          unused_lsb;
    logic [1:0]    lvalid;
    logic [TW-1:0] ltag [2];
    logic [31:0]   ldata [2];
    logic [1:0]    hit;
    logic          any_hit;
    logic          hit_idx;
    logic          start_fetch;
    logic [TW-1:0] ftag;
    logic [15:0]   lo_buf;
    logic          victim;
    logic          drop;
    logic          lru;
    logic          fill_we;
    logic          fill_vld;
    logic [31:0]   fill_dat;

    assign cur_tag     = rom_addr[AW-1:2];
    assign unused_lsb  = ^rom_addr[1:0];
    assign any_hit     = |hit;
    assign hit_idx     = hit[1];
    assign start_fetch = rom_cs & ~any_hit & ~flush;
    assign fill_we     = (state == HI) & sdram_dok;
    // A flush seen at any point of the fetch, including the final beat, voids the line.
    assign fill_vld    = ~(drop | flush);
    assign fill_dat    = {sdram_data, lo_buf};

    for (genvar i = 0; i < 2; i++) begin : g_line
        jtvigil_romrsp_line #(.TW(TW)) u_line (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (fill_we && (victim == 1'(i))),
            .wvld  (fill_vld),
            .clr   (flush),
            .wtag  (ftag),
            .wdat  (fill_dat),
            .valid (lvalid[i]),
            .tag   (ltag[i]),
            .data  (ldata[i])
        );
        assign hit[i] = rom_cs & lvalid[i] & (ltag[i] == cur_tag);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt_state;
    end

    always_comb begin
        nxt_state = state;
        case (state)
            IDLE:    if (start_fetch) nxt_state = REQ;
            REQ:     if (sdram_ack)   nxt_state = LO;
            LO:      if (sdram_dok)   nxt_state = REQ2;
            REQ2:    if (sdram_ack)   nxt_state = HI;
            HI:      if (sdram_dok)   nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
            ftag       <= '0;
            lo_buf     <= '0;
            victim     <= 1'b0;
            drop       <= 1'b0;
            lru        <= 1'b0;
            rom_ok     <= 1'b0;
            rom_data   <= '0;
        end else begin
            rom_ok <= any_hit & ~flush;
            if (any_hit) begin
                rom_data <= ldata[hit_idx];
                lru      <= ~hit_idx;
            end
            if (state == IDLE) drop <= 1'b0;
            else if (flush)    drop <= 1'b1;
            case (state)
                IDLE: if (start_fetch) begin
                    ftag       <= cur_tag;
                    victim     <= !lvalid[0] ? 1'b0 : (!lvalid[1] ? 1'b1 : lru);
                    sdram_addr <= {cur_tag, 1'b0};
                    sdram_req  <= 1'b1;
                end
                REQ, REQ2: if (sdram_ack) sdram_req <= 1'b0;
                LO: if (sdram_dok) begin
                    lo_buf     <= sdram_data;
                    sdram_addr <= {ftag, 1'b1};
                    sdram_req  <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_jtvigil_romrsp.sv
// Bench for jtvigil_romrsp: directed scenarios plus random traffic, checked by a scoreboard
// against a word-level ROM model with a flush epoch.
module tb_jtvigil_romrsp;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        rom_cs;
    logic [17:0] rom_addr;
    logic [31:0] rom_data;
    logic        rom_ok;
    logic        flush;
    logic        sdram_req;
    logic [16:0] sdram_addr;
    logic        sdram_ack;
    logic        sdram_dok;
    logic [15:0] sdram_data;

    int n_checks = 0;
    int n_errors = 0;
    int unsigned epoch = 0;
    bit sd_en = 1'b1;
    logic [16:0] fetch_log[$];
    logic [16:0] sd_a;

    typedef struct {
        bit          allowed;
        logic [17:0] addr;
        logic [31:0] exp;
    } sb_t;
    sb_t sb_q[$];
    sb_t rec;
    sb_t mon;

    jtvigil_romrsp dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rom_cs     (rom_cs),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .rom_ok     (rom_ok),
        .flush      (flush),
        .sdram_req  (sdram_req),
        .sdram_addr (sdram_addr),
        .sdram_ack  (sdram_ack),
        .sdram_dok  (sdram_dok),
        .sdram_data (sdram_data)
    );

    always #5 clk = ~clk;

    // ROM contents as seen by the SDRAM; a flush (download) changes the whole image.
    function automatic logic [15:0] mem16(input logic [16:0] a);
        logic [31:0] h;
        if (epoch == 0 && a == 17'h00082) return 16'hBEEF;
        if (epoch == 0 && a == 17'h00083) return 16'hDEAD;
        h = ({15'd0, a} * 32'h9E3779B1) ^ (epoch * 32'h7F4A7C15);
        return h[31:16] ^ h[15:0];
    endfunction

    function automatic logic [31:0] exp_word(input logic [17:0] a);
        return {mem16({a[17:2], 1'b1}), mem16({a[17:2], 1'b0})};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic cs, input logic [17:0] a, input logic fl);
        @(posedge clk);
        #1;
        if (fl && !flush) epoch++;
        rom_cs   = cs;
        rom_addr = a;
        flush    = fl;
    endtask

    task automatic wait_ok(input string nm);
        bit got;
        got = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rom_ok) begin
                got = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!got) begin
            n_errors++;
            $display("FAIL %s: rom_ok never rose, got 0, expected 1", nm);
        end
    endtask

    // SDRAM controller model: random ack and data latencies, one beat per request.
    initial begin
        sdram_ack  = 1'b0;
        sdram_dok  = 1'b0;
        sdram_data = '0;
        forever begin
            @(posedge clk);
            #1;
            if (sd_en && rst_n && sdram_req) begin
                sd_a = sdram_addr;
                fetch_log.push_back(sd_a);
                repeat ($urandom_range(0, 2)) @(posedge clk);
                sdram_ack = 1'b1;
                @(posedge clk);
                #1;
                sdram_ack = 1'b0;
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk);
                    #1;
                end
                sdram_data = mem16(sd_a);
                sdram_dok  = 1'b1;
                @(posedge clk);
                #1;
                sdram_dok  = 1'b0;
                sdram_data = 16'h0BAD;
            end
        end
    end

    // Expectation capture: what rom_ok/rom_data may show after this edge.
    initial forever begin
        @(posedge clk);
        rec.allowed = rst_n && rom_cs && !flush;
        rec.addr    = rom_addr;
        rec.exp     = exp_word(rom_addr);
        sb_q.push_back(rec);
    end

    // Monitor: every asserted rom_ok must carry the word of the address presented one edge earlier.
    initial forever begin
        @(negedge clk);
        if (sb_q.size() > 0) begin
            mon = sb_q.pop_front();
            if (rom_ok) begin
                n_checks++;
                if (!mon.allowed || rom_data !== mon.exp) begin
                    n_errors++;
                    $display("FAIL scoreboard addr=%h: got ok=1 data=%h, expected allowed=%0d data=%h",
                             mon.addr, rom_data, mon.allowed, mon.exp);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1, "watchdog");
    end

    logic [17:0] pool [6];
    logic [17:0] ra;
    int          mode;
    int          n0;
    bit          got;

    initial begin
        rst_n    = 1'b0;
        rom_cs   = 1'b0;
        rom_addr = '0;
        flush    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset rom_ok", 32'(rom_ok), 32'd0);
        chk("reset rom_data", rom_data, 32'd0);
        chk("reset sdram_req", 32'(sdram_req), 32'd0);
        chk("reset sdram_addr", 32'(sdram_addr), 32'd0);
        rst_n = 1'b1;

        // Cold miss
        fetch_log.delete();
        drive(1'b1, 18'h00104, 1'b0);
        wait_ok("cold miss ok");
        chk("cold miss rom_data", rom_data, 32'hDEADBEEF);
        chk("cold miss fetch count", 32'(fetch_log.size()), 32'd2);
        chk("cold miss beat0 addr", 32'(fetch_log[0]), 32'h00082);
        chk("cold miss beat1 addr", 32'(fetch_log[1]), 32'h00083);

        // Hit after a second fill
        drive(1'b1, 18'h00200, 1'b0);
        wait_ok("fill 0x200");
        n0 = fetch_log.size();
        drive(1'b1, 18'h00104, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("hit rom_ok 1 clk", 32'(rom_ok), 32'd1);
        chk("hit rom_data", rom_data, 32'hDEADBEEF);
        chk("hit no sdram_req", 32'(sdram_req), 32'd0);
        chk("hit no fetch", 32'(fetch_log.size()), 32'(n0));

        // LRU: A, B filled, A touched, C evicts B
        drive(1'b0, 18'h0, 1'b1);
        drive(1'b0, 18'h0, 1'b0);
        drive(1'b1, 18'h00004, 1'b0);
        wait_ok("fill A");
        drive(1'b1, 18'h00008, 1'b0);
        wait_ok("fill B");
        drive(1'b1, 18'h00004, 1'b0);
        wait_ok("touch A");
        n0 = fetch_log.size();
        drive(1'b1, 18'h0000C, 1'b0);
        wait_ok("fill C");
        chk("lru C fetched", 32'(fetch_log.size()), 32'(n0 + 2));
        drive(1'b1, 18'h00004, 1'b0);
        wait_ok("A after C");
        chk("lru A kept", 32'(fetch_log.size()), 32'(n0 + 2));
        drive(1'b1, 18'h00008, 1'b0);
        wait_ok("B after C");
        chk("lru B evicted", 32'(fetch_log.size()), 32'(n0 + 4));

        // Address change while waiting for the low beat
        fetch_log.delete();
        drive(1'b1, 18'h00010, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (fetch_log.size() >= 1 && !sdram_req) begin
                got = 1'b1;
                break;
            end
        end
        chk("reach LO", 32'(got), 32'd1);
        rom_addr = 18'h00014;
        wait_ok("changed addr ok");
        chk("changed addr data", rom_data, exp_word(18'h00014));
        chk("changed addr fetches", 32'(fetch_log.size()), 32'd4);
        chk("first fetch completed", 32'(fetch_log[1]), 32'h00009);
        chk("second fetch tag", 32'(fetch_log[2]), 32'h0000A);
        drive(1'b1, 18'h00010, 1'b0);
        wait_ok("0x010 back");

        // Flush during the second request
        fetch_log.delete();
        drive(1'b1, 18'h00300, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (fetch_log.size() >= 2) begin
                got = 1'b1;
                break;
            end
        end
        chk("reach REQ2", 32'(got), 32'd1);
        epoch++;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        wait_ok("refetch after flush");
        chk("flush refetch count", 32'(fetch_log.size()), 32'd4);
        chk("flush refetch beat0", 32'(fetch_log[2]), 32'h00180);
        chk("flush refetch beat1", 32'(fetch_log[3]), 32'h00181);

        // Asynchronous reset in the middle of a request
        drive(1'b1, 18'h00100, 1'b0);
        wait_ok("fill 0x100");
        sd_en = 1'b0;
        drive(1'b1, 18'h003F0, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sdram_req) begin
                got = 1'b1;
                break;
            end
        end
        chk("req before reset", 32'(got), 32'd1);
        #2;
        rst_n  = 1'b0;
        rom_cs = 1'b0;
        #1;
        chk("async reset sdram_req", 32'(sdram_req), 32'd0);
        chk("async reset sdram_addr", 32'(sdram_addr), 32'd0);
        chk("async reset rom_ok", 32'(rom_ok), 32'd0);
        chk("async reset rom_data", rom_data, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        sd_en = 1'b1;
        fetch_log.delete();
        drive(1'b1, 18'h00100, 1'b0);
        wait_ok("0x100 after reset");
        chk("refetch after reset count", 32'(fetch_log.size()), 32'd2);
        chk("refetch after reset addr", 32'(fetch_log[0]), 32'h00080);

        // Random traffic
        pool[0] = 18'h00104;
        pool[1] = 18'h00200;
        pool[2] = 18'h00004;
        pool[3] = 18'h00008;
        pool[4] = 18'h0000C;
        pool[5] = 18'h3FFFC;
        for (int t = 0; t < 300; t++) begin
            mode = $urandom_range(0, 9);
            ra   = pool[$urandom_range(0, 5)];
            ra[1:0] = 2'($urandom_range(0, 3));
            if (mode == 0) begin
                drive(1'($urandom_range(0, 1)), ra, 1'b1);
            end else if (mode == 1) begin
                drive(1'b0, ra, 1'b0);
                repeat ($urandom_range(1, 3)) @(posedge clk);
            end else if (mode == 2) begin
                drive(1'b1, ra, 1'b0);
                repeat ($urandom_range(1, 6)) @(posedge clk);
            end else begin
                drive(1'b1, ra, 1'b0);
                wait_ok("random access");
                repeat ($urandom_range(0, 2)) @(posedge clk);
            end
        end

        drive(1'b0, 18'h0, 1'b0);
        repeat (40) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
